// File: rtl/divider_iterative_rv_pkg.sv
// ============================================================================
// divider_iterative_rv_pkg : shared types and widths for the iterative divider
// Revision: 1.0
// ============================================================================
`default_nettype none

package divider_iterative_rv_pkg;

    localparam int DIV_WIDTH      = 64;
    localparam int DIV_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef struct packed {
        logic                 op_signed;
        logic                 op_word;
        logic [DIV_WIDTH-1:0] a;
        logic [DIV_WIDTH-1:0] b;
    } div_req_t;

endpackage

`default_nettype wire

// File: rtl/div_restoring_step.sv
// ============================================================================
// div_restoring_step : one combinational radix-2 restoring division step
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_restoring_step
    import divider_iterative_rv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // The shifted partial remainder needs one extra bit before the compare.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_take;

    assign w_shift = {rem_in, quo_in[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, divisor};
    assign w_take  = (w_shift >= {1'b0, divisor});

    assign rem_out = w_take ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], w_take};

endmodule

`default_nettype wire

// File: rtl/divider_iterative_rv.sv
// ============================================================================
// divider_iterative_rv : radix-2 restoring divider with RISC-V result rules,
//                        word mode, valid/ready handshake and flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module divider_iterative_rv
    import divider_iterative_rv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic             op_word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic logic [WIDTH-1:0] ext_half(input logic [HALF-1:0] x);
        return {{HALF{x[HALF-1]}}, x};
    endfunction

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_word;

    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min;
    logic             w_b_zero, w_ovf, w_special;
    logic [WIDTH-1:0] w_sp_quot, w_sp_rem;
    logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix;

    // Operands viewed over N bits, then sign/zero-extended so one path serves both modes.
    assign w_a_neg = op_signed & (op_word ? a[HALF-1] : a[WIDTH-1]);
    assign w_b_neg = op_signed & (op_word ? b[HALF-1] : b[WIDTH-1]);
    assign w_a_ext = op_word ? {{HALF{op_signed & a[HALF-1]}}, a[HALF-1:0]} : a;
    assign w_b_ext = op_word ? {{HALF{op_signed & b[HALF-1]}}, b[HALF-1:0]} : b;
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_min   = op_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                             : {1'b1, {(WIDTH-1){1'b0}}};

    assign w_b_zero  = (w_b_ext == '0);
    assign w_ovf     = op_signed && (w_a_ext == w_min) && (w_b_ext == '1);
    assign w_special = w_b_zero || w_ovf;
    assign w_sp_quot = w_b_zero ? '1 : w_a_ext;
    assign w_sp_rem  = w_b_zero ? (op_word ? ext_half(a[HALF-1:0]) : a) : '0;

    div_restoring_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_div),
        .rem_out (w_rem_nxt),
        .quo_out (w_quo_nxt)
    );

    assign w_q_fix = r_sign_q ? -r_quo : r_quo;
    assign w_r_fix = r_sign_r ? -r_rem : r_rem;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid && !flush) w_state_nxt = w_special ? DONE : CALC;
            CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_word   <= 1'b0;
            quot     <= '0;
            rem      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        r_word   <= op_word;
                        r_sign_q <= w_a_neg ^ w_b_neg;
                        r_sign_r <= w_a_neg;
                        r_div    <= w_b_mag;
                        r_rem    <= '0;
                        // Word dividend sits in the top half so N steps shift it all through.
                        r_quo    <= op_word ? (w_a_mag << HALF) : w_a_mag;
                        r_cnt    <= op_word ? CNT_W'(HALF) : CNT_W'(WIDTH);
                        if (w_special) begin
                            quot <= w_sp_quot;
                            rem  <= w_sp_rem;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIX: begin
                    quot <= r_word ? ext_half(w_q_fix[HALF-1:0]) : w_q_fix;
                    rem  <= r_word ? ext_half(w_r_fix[HALF-1:0]) : w_r_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divider_iterative_rv.sv
// ============================================================================
// tb_divider_iterative_rv : directed and random checks of divider_iterative_rv
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_divider_iterative_rv;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_signed = 1'b0;
    logic        op_word = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quot;
    logic [63:0] rem;

    int checks = 0;
    int errors = 0;

    divider_iterative_rv #(.WIDTH(64)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_signed (op_signed),
        .op_word   (op_word),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics computed with plain integer arithmetic.
    function automatic void model(input bit s, input bit w, input logic [63:0] av,
                                  input logic [63:0] bv, output logic [63:0] q,
                                  output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        int          ia, ib;
        longint      sa, sb;
        a32 = av[31:0];
        b32 = bv[31:0];
        ia  = a32;
        ib  = b32;
        sa  = av;
        sb  = bv;
        q   = '0;
        r   = '0;
        if (w) begin
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
            else if (s) begin q32 = ia / ib; r32 = ia % ib; end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (bv == 0) begin q = '1; r = av; end
            else if (s && av == 64'h8000_0000_0000_0000 && bv == '1) begin q = av; r = 0; end
            else if (s) begin q = sa / sb; r = sa % sb; end
            else begin q = av / bv; r = av % bv; end
        end
    endfunction

    function automatic bit is_special(input bit s, input bit w, input logic [63:0] av,
                                      input logic [63:0] bv);
        if (w) return (bv[31:0] == 0) || (s && av[31:0] == 32'h8000_0000 && bv[31:0] == '1);
        return (bv == 0) || (s && av == 64'h8000_0000_0000_0000 && bv == '1);
    endfunction

    task automatic run_op(input string tag, input bit s, input bit w, input logic [63:0] av,
                          input logic [63:0] bv, output logic [63:0] q, output logic [63:0] r);
        logic [63:0] eq, er;
        int          lat, exp_lat;
        bit          busy_bad;
        model(s, w, av, bv, eq, er);
        exp_lat = is_special(s, w, av, bv) ? 1 : (w ? 34 : 66);
        @(negedge clk);
        in_valid = 1'b1; op_signed = s; op_word = w; a = av; b = bv;
        chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        busy_bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".in_ready_busy"}, 64'(busy_bad), 64'd0);
        chk({tag, ".quot"}, quot, eq);
        chk({tag, ".rem"}, rem, er);
        q = quot;
        r = rem;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] q, r, eq, er, av, bv;
        bit          s, w, seen;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.quot", quot, 64'd0);
        chk("reset.rem", rem, 64'd0);
        resetn = 1'b1;

        run_op("u64", 1'b0, 1'b0, 64'd100, 64'd7, q, r);
        chk("u64.q14", q, 64'd14);
        chk("u64.r2", r, 64'd2);
        run_op("s_neg_a", 1'b1, 1'b0, -64'sd7, 64'sd2, q, r);
        chk("s_neg_a.q", q, -64'sd3);
        chk("s_neg_a.r", r, -64'sd1);
        run_op("s_neg_b", 1'b1, 1'b0, 64'sd7, -64'sd2, q, r);
        chk("s_neg_b.q", q, -64'sd3);
        chk("s_neg_b.r", r, 64'd1);
        run_op("divzero", 1'b0, 1'b0, 64'h1234, 64'd0, q, r);
        chk("divzero.q", q, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("divzero.r", r, 64'h1234);
        run_op("ovf64", 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, q, r);
        chk("ovf64.q", q, 64'h8000_0000_0000_0000);
        chk("ovf64.r", r, 64'd0);
        run_op("ovf32", 1'b1, 1'b1, 64'h8000_0000, '1, q, r);
        chk("ovf32.q", q, 64'hFFFF_FFFF_8000_0000);
        run_op("word_u", 1'b0, 1'b1, 64'hDEAD_0000_0000_0010, 64'd3, q, r);
        chk("word_u.q", q, 64'd5);
        chk("word_u.r", r, 64'd1);
        run_op("word_s", 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, q, r);
        chk("word_s.q", q, 64'hFFFF_FFFF_FFFF_FFFE);

        // Flush ten cycles into CALC.
        @(negedge clk);
        in_valid = 1'b1; op_signed = 1'b0; op_word = 1'b0; a = 64'd100; b = 64'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("flush.no_result", 64'(seen), 64'd0);

        // Flush in the same cycle as a request: nothing is accepted.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_req.in_ready", 64'(in_ready), 64'd1);

        // Result held while out_ready stays low, then reset in DONE.
        model(1'b1, 1'b0, -64'sd1000, 64'sd33, eq, er);
        @(negedge clk);
        in_valid = 1'b1; op_signed = 1'b1; op_word = 1'b0; a = -64'sd1000; b = 64'sd33;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold.reached_done", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold.out_valid", 64'(out_valid), 64'd1);
            chk("hold.quot", quot, eq);
            chk("hold.rem", rem, er);
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rst_done.out_valid", 64'(out_valid), 64'd0);
        chk("rst_done.in_ready", 64'(in_ready), 64'd1);
        chk("rst_done.quot", quot, 64'd0);

        for (int i = 0; i < 40; i++) begin
            s  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            av = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       bv = '0;
                1:       bv = '1;
                2:       bv = {$urandom, $urandom} >> $urandom_range(0, 63);
                default: bv = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 5) == 0) begin
                if (w) av[31:0] = 32'h8000_0000;
                else   av = 64'h8000_0000_0000_0000;
            end
            run_op("rand", s, w, av, bv, q, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
